// File: rtl/branch_resolver_pkg.sv
// branch_resolver_pkg: shared FSM state encoding, branch opcodes and wait-counter width.
package branch_resolver_pkg;
  typedef logic [1:0] state_t;
  localparam state_t S_IDLE = 2'd0;
  localparam state_t S_WAIT = 2'd1;
  localparam state_t S_REDIRECT = 2'd2;
  localparam logic [4:0] OPC_BRANCH = 5'b11000;
  localparam logic [4:0] OPC_JAL = 5'b11011;
  localparam logic [4:0] OPC_JALR = 5'b11001;
  localparam int CNT_W = 4;
  function automatic logic is_branch_op(logic [4:0] op);
    return op == OPC_BRANCH || op == OPC_JAL || op == OPC_JALR;
  endfunction
endpackage

// File: rtl/branch_resolver.sv
// branch_resolver: stalls fetch on a branch until EX resolves it, then redirects or times out.
// Optional taken/not-taken statistics counters under BRANCH_RESOLVER_STATS_EN.
module branch_resolver
  import branch_resolver_pkg::*;
#(
  parameter int WIDTH_DATA_LENGTH = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         br_detected,
  input  logic                         if_valid,
  input  logic                         ex_resolve,
  input  logic                         ex_taken,
  input  logic [WIDTH_DATA_LENGTH-1:0] ex_target,
  output logic                         stall_fetch,
  output logic                         redirect,
  output logic [WIDTH_DATA_LENGTH-1:0] redirect_pc,
  output logic                         flush_if,
  output logic                         timeout_err
`ifdef BRANCH_RESOLVER_STATS_EN
  ,
  output logic [15:0]                  taken_cnt,
  output logic [15:0]                  not_taken_cnt
`endif
);
  state_t r_state;
  state_t w_next;
  logic [CNT_W-1:0] r_cnt;
  logic w_accept;
  logic w_resolve;
  logic w_timeout;
  assign w_accept = r_state == S_IDLE && br_detected && if_valid;
  assign w_resolve = r_state == S_WAIT && ex_resolve;
  // A resolution in the timeout cycle takes priority over the timeout.
  assign w_timeout = r_state == S_WAIT && !ex_resolve && r_cnt == CNT_W'(MAX_WAIT - 1);
  always_comb
    w_next = w_accept ? S_WAIT :
             w_resolve ? (ex_taken ? S_REDIRECT : S_IDLE) :
             (w_timeout || r_state == S_REDIRECT) ? S_IDLE : r_state;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt <= '0;
      redirect_pc <= '0;
      timeout_err <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) r_cnt <= '0;
      else if (r_state == S_WAIT && r_cnt != '1) r_cnt <= r_cnt + 1'b1;
      if (w_resolve && ex_taken) redirect_pc <= ex_target;
      if (w_timeout) timeout_err <= 1'b1;
    end
  end
  assign stall_fetch = r_state == S_WAIT || w_accept;
  assign redirect = r_state == S_REDIRECT;
  assign flush_if = r_state == S_REDIRECT;
`ifdef BRANCH_RESOLVER_STATS_EN
  logic [15:0] r_taken_cnt;
  logic [15:0] r_not_taken_cnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_taken_cnt <= '0;
      r_not_taken_cnt <= '0;
    end else if (w_resolve) begin
      if (ex_taken && r_taken_cnt != 16'hFFFF) r_taken_cnt <= r_taken_cnt + 1'b1;
      if (!ex_taken && r_not_taken_cnt != 16'hFFFF) r_not_taken_cnt <= r_not_taken_cnt + 1'b1;
    end
  end
  assign taken_cnt = r_taken_cnt;
  assign not_taken_cnt = r_not_taken_cnt;
`endif
endmodule
